// File: rtl/piece_queue_gen_pkg.sv
// Shared game types and constants for the piece generator.
// Tile encoding, bag size and LFSR constants live here.
package GamePkg;

    localparam int NEXT_PIECES_COUNT = 5;
    localparam int BAG_SIZE = 7;
    localparam logic [15:0] PIECE_LFSR_MASK = 16'hB400;
    localparam logic [15:0] PIECE_LFSR_RESET = 16'hACE1;

    typedef enum logic [2:0] {
        BLANK  = 3'd0,
        TILE_I = 3'd1,
        TILE_O = 3'd2,
        TILE_T = 3'd3,
        TILE_J = 3'd4,
        TILE_L = 3'd5,
        TILE_S = 3'd6,
        TILE_Z = 3'd7
    } tile_type_t;

    // Bag index order is I, O, T, J, L, S, Z.
    function automatic tile_type_t bag_to_tile(logic [2:0] idx);
        tile_type_t t;
        case (idx)
            3'd0:    t = TILE_I;
            3'd1:    t = TILE_O;
            3'd2:    t = TILE_T;
            3'd3:    t = TILE_J;
            3'd4:    t = TILE_L;
            3'd5:    t = TILE_S;
            3'd6:    t = TILE_Z;
            default: t = BLANK;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/piece_queue_gen_bag_draw.sv
// Combinational 7-bag draw: picks the k-th remaining piece,
// k = rnd mod popcount(mask), and returns the refilled next mask.
module bag_draw
    import GamePkg::*;
(
    input  logic [BAG_SIZE-1:0] bag_mask,
    input  logic [7:0]          rnd,
    output logic [2:0]          draw_idx,
    output logic [BAG_SIZE-1:0] mask_next
);

    logic [2:0]          pop_cnt;
    logic [7:0]          k;
    logic [2:0]          seen;
    logic [BAG_SIZE-1:0] cleared;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < BAG_SIZE; i++) begin
            pop_cnt = pop_cnt + {2'b0, bag_mask[i]};
        end
        // An empty mask never occurs; the guard keeps the modulo defined.
        k = (pop_cnt == 3'd0) ? 8'd0 : rnd % {5'd0, pop_cnt};
        seen     = '0;
        draw_idx = '0;
        for (int i = 0; i < BAG_SIZE; i++) begin
            if (bag_mask[i]) begin
                if ({5'd0, seen} == k) begin
                    draw_idx = 3'(i);
                end
                seen = seen + 3'd1;
            end
        end
        cleared   = bag_mask & ~(7'd1 << draw_idx);
        mask_next = (cleared == '0) ? '1 : cleared;
    end

endmodule

// File: rtl/piece_queue_gen.sv
// Upcoming-piece lookahead queue fed by a seeded 7-bag randomizer.
// Slot 0 is the next piece; pop is accepted only while the queue is full.
module piece_queue_gen
    import GamePkg::*;
#(
    parameter int          DEPTH      = NEXT_PIECES_COUNT,
    parameter logic [15:0] LFSR_RESET = PIECE_LFSR_RESET
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_load,
    input  logic [15:0] seed,
    input  logic       pop,
    output tile_type_t pieces_queue [DEPTH],
    output logic       queue_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]       cnt_q, cnt_d, ins_pos;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [BAG_SIZE-1:0] bag_q, bag_d, bag_next;
    logic [2:0]          draw_idx;
    logic                ready_q, ready_d, pop_acc;
    tile_type_t          queue_q [DEPTH];
    tile_type_t          queue_d [DEPTH];

    bag_draw u_draw (
        .bag_mask  (bag_q),
        .rnd       (lfsr_q[7:0]),
        .draw_idx  (draw_idx),
        .mask_next (bag_next)
    );

    always_comb begin
        pop_acc = pop & ready_q;
        ins_pos = cnt_q - CW'(pop_acc);
        queue_d = queue_q;
        bag_d   = bag_q;
        cnt_d   = cnt_q;
        if (pop_acc) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                queue_d[i] = queue_q[i+1];
            end
            queue_d[DEPTH-1] = BLANK;
        end
        if (int'(ins_pos) < DEPTH) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(ins_pos)) begin
                    queue_d[i] = bag_to_tile(draw_idx);
                end
            end
            bag_d = bag_next;
            cnt_d = ins_pos + CW'(1);
        end
        ready_d = (int'(cnt_d) == DEPTH);
        // A seed load replaces this cycle's LFSR step.
        if (seed_load) begin
            lfsr_d = (seed == 16'h0) ? LFSR_RESET : seed;
        end else begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^
                     (lfsr_q[0] ? PIECE_LFSR_MASK : 16'h0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
            bag_q   <= '1;
            lfsr_q  <= LFSR_RESET;
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= BLANK;
            end
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            bag_q   <= bag_d;
            lfsr_q  <= lfsr_d;
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= queue_d[i];
            end
        end
    end

    assign pieces_queue = queue_q;
    assign queue_ready  = ready_q;

endmodule

// File: tb/tb_piece_queue_gen.sv
// Scoreboard bench for piece_queue_gen with hand-derived draw sequences.
// Stimulus queues expected pops; a negedge monitor checks them.
module tb_piece_queue_gen;
    import GamePkg::*;

    localparam int D = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0;
    logic        pop = 1'b0;
    tile_type_t  pq [D];
    logic        queue_ready;

    int errors = 0;
    int checks = 0;

    tile_type_t exp_q [$];
    bit         bag_mode = 1'b0;
    int         gcnt = 0;
    logic [6:0] gseen = '0;
    tile_type_t mon_got, mon_exp;

    // Reset seed 0xACE1: O S T I J Z L | L S J
    tile_type_t seq_rst [10] = '{TILE_O, TILE_S, TILE_T, TILE_I, TILE_J,
                                 TILE_Z, TILE_L, TILE_L, TILE_S, TILE_J};
    // Seed 0 loaded once full: queued O S T I J, then Z L I O S
    tile_type_t seq_s0 [10] = '{TILE_O, TILE_S, TILE_T, TILE_I, TILE_J,
                                TILE_Z, TILE_L, TILE_I, TILE_O, TILE_S};
    // Seed 0x1234 loaded once full: queued O S T I J, then L Z O S I
    tile_type_t seq_s1 [10] = '{TILE_O, TILE_S, TILE_T, TILE_I, TILE_J,
                                TILE_L, TILE_Z, TILE_O, TILE_S, TILE_I};

    always #5 clk = ~clk;

    piece_queue_gen #(.DEPTH(D), .LFSR_RESET(16'hACE1)) dut (
        .clk          (clk),
        .rst          (rst),
        .seed_load    (seed_load),
        .seed         (seed),
        .pop          (pop),
        .pieces_queue (pq),
        .queue_ready  (queue_ready)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && pop && queue_ready) begin
            mon_got = pq[0];
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("pop_piece", int'(mon_got), int'(mon_exp));
            end else if (!bag_mode) begin
                chk("pop_unexpected", 1, 0);
            end
            if (bag_mode) begin
                chk("pop_not_blank", int'(mon_got == BLANK), 0);
                if (mon_got != BLANK)
                    gseen = gseen | (7'd1 << (int'(mon_got) - 1));
                gcnt++;
                if (gcnt == 7) begin
                    chk("bag_perm", int'(gseen), 7'h7f);
                    gcnt  = 0;
                    gseen = '0;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        seed_load = 1'b0;
        cyc(1);
        for (int i = 0; i < D; i++)
            chk($sformatf("rst_slot%0d", i), int'(pq[i]), int'(BLANK));
        chk("rst_ready", int'(queue_ready), 0);
        rst = 1'b0;
    endtask

    task automatic fill_check(input bit early_pop);
        for (int e = 1; e <= D; e++) begin
            pop = early_pop && (e < D);
            cyc(1);
            for (int i = 0; i < D; i++)
                chk($sformatf("fill_e%0d_s%0d", e, i), int'(pq[i]),
                    (i < e) ? int'(seq_rst[i]) : int'(BLANK));
            chk($sformatf("fill_ready_e%0d", e), int'(queue_ready),
                int'(e == D));
        end
        pop = 1'b0;
    endtask

    task automatic seed_run(input logic [15:0] s, input bit use_s1);
        pop = 1'b0;
        do_reset();
        fill_check(1'b0);
        seed_load = 1'b1;
        seed = s;
        cyc(1);
        seed_load = 1'b0;
        for (int i = 0; i < D; i++)
            chk($sformatf("seed_hold_s%0d", i), int'(pq[i]),
                int'(seq_rst[i]));
        chk("seed_hold_ready", int'(queue_ready), 1);
        for (int i = 0; i < 10; i++)
            exp_q.push_back(use_s1 ? seq_s1[i] : seq_s0[i]);
        pop = 1'b1;
        cyc(10);
        pop = 1'b0;
        cyc(1);
        chk("seed_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset fill and back-to-back pops
        do_reset();
        fill_check(1'b0);
        pop = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(seq_rst[k]);
            cyc(1);
            for (int i = 0; i < D; i++)
                if (k + 1 + i < 10)
                    chk($sformatf("b2b_k%0d_s%0d", k, i), int'(pq[i]),
                        int'(seq_rst[k+1+i]));
            chk($sformatf("b2b_ready_k%0d", k), int'(queue_ready), 1);
        end
        pop = 1'b0;
        cyc(1);
        chk("b2b_drained", exp_q.size(), 0);

        // Zero seed behaves as the reset seed; 0x1234 is repeatable
        seed_run(16'h0000, 1'b0);
        seed_run(16'h1234, 1'b1);
        seed_run(16'h1234, 1'b1);

        // Early pops ignored, then 700 pops checked bag by bag
        do_reset();
        fill_check(1'b1);
        gcnt = 0;
        gseen = '0;
        bag_mode = 1'b1;
        for (int i = 0; i < 10; i++)
            exp_q.push_back(seq_rst[i]);
        pop = 1'b1;
        cyc(700);
        chk("bag_group_aligned", gcnt, 0);

        // Reset while full and popping
        do_reset();
        bag_mode = 1'b0;
        pop = 1'b0;
        fill_check(1'b0);

        cyc(2);
        chk("final_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piece_queue_gen.md
# piece_queue_gen

Generates the upcoming-tetromino sequence with a seeded 7-bag randomizer. Holds it in a fixed-depth, shift-style lookahead queue. Slot 0 is the next piece to spawn. The whole queue drives the next-piece preview panel directly, and the spawn logic consumes slot 0 through a pop strobe.

## Interface
- `DEPTH`, default `NEXT_PIECES_COUNT`: number of queue slots. Must be at least 1.
- `LFSR_RESET`, default `16'hACE1`: LFSR value after reset. Also substituted whenever a zero seed is loaded.

Ports:
- `clk` input 1: single clock for all state.
- `rst` input 1: synchronous, active-high reset.
- `seed_load` input 1: load `seed` into the LFSR this cycle.
- `seed` input 16: new LFSR value.
- `pop` input 1: spawn logic takes slot 0.
- `pieces_queue` output `tile_type_t [DEPTH]`: registered queue contents; slot 0 is the next piece.
- `queue_ready` output 1: all `DEPTH` slots are valid. `pop` is honoured only while this is high.

## Operation
- Bag index order is fixed: 0=I, 1=O, 2=T, 3=J, 4=L, 5=S, 6=Z.
- `bag_mask[6:0]`: bit set means that piece is still in the current bag.
- LFSR is a 16-bit Galois LFSR with mask 0xB400. Each step: `lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0)`. It steps every cycle that is not reset or seed load.
- Draw, combinational, uses the current register values:
  - c = popcount(`bag_mask`), always in 1..7.
  - k = `lfsr[7:0]` mod c.
  - The drawn piece is the k-th set bit of `bag_mask`, counting from the LSB starting at 0.
- Valid count `cnt` runs 0..`DEPTH`. `pop_acc` = `pop & queue_ready`.
- Per cycle:
  - If `pop_acc`: shift slots down by one (slot i ← slot i+1); the top slot becomes BLANK.
  - Insert position p = `cnt - pop_acc`.
  - If p < `DEPTH`: write the drawn piece into slot p, clear its bit in `bag_mask`, and set `cnt <= p + 1`. Otherwise hold.
- Bag refill: if clearing a bit leaves `bag_mask` zero, the next state is 7'b1111111. No empty-bag cycle ever exists.
- `pop` while `queue_ready` is low is ignored. No state changes from it.
- `seed_load`:
  - Sets `lfsr <= (seed == 0) ? LFSR_RESET : seed`. The LFSR does not also step that cycle.
  - The bag and queue are unaffected, and a draw still occurs that cycle using the old LFSR value.
- Priority: `rst` > `seed_load` > normal operation.
- Any 7 consecutive draws that start at a bag boundary contain each piece exactly once.

## Timing
- Reset values:
  - `pieces_queue`: all BLANK.
  - `cnt` = 0, `queue_ready` = 0.
  - `bag_mask` = 7'b1111111, `lfsr` = `LFSR_RESET`.
- Reset applied mid-operation discards the queue and bag on the next edge.
- Fill: one piece per cycle. Slot j becomes valid on the (j+1)-th edge after `rst` deasserts.
- `queue_ready` is a register equal to (`cnt == DEPTH`). It rises on edge `DEPTH` after reset release.
- Pop latency:
  - `pop` sampled high with `queue_ready` high → the shifted queue appears on the next edge.
  - A pop cycle always refills the top slot, so `queue_ready` stays high and back-to-back pops every cycle are allowed.
- All outputs are registered. There is no combinational path from `pop` or `seed` to any output.

## Structure
- GamePkg:
  - Existing `tile_type_t` and `NEXT_PIECES_COUNT`.
  - Add `BAG_SIZE = 7`, `PIECE_LFSR_MASK = 16'hB400`, `PIECE_LFSR_RESET = 16'hACE1`.
  - Add a function mapping bag index to `tile_type_t`.
- Sub-module `bag_draw`: purely combinational (`bag_mask`, `lfsr[7:0]` → drawn index, next mask with refill). Unit-testable in isolation.
- LFSR, queue shift register and counters live in `piece_queue_gen`.

## Test plan
- Reset fill: reset with default seed.
  - First draw: c=7, 0xE1 mod 7 = 1 → slot0 = O.
  - LFSR becomes 0xE270. Second draw: c=6, 0x70 mod 6 = 4 → slot1 = S.
  - `queue_ready` rises exactly at edge `DEPTH`.
- Bag property: pop continuously for 700 cycles after ready. Every aligned group of 7 popped pieces is a permutation of {I,O,T,J,L,S,Z}; no BLANK is ever popped.
- Early pop: assert `pop` during cycles 1..`DEPTH`-1 after reset. Fill sequence and timing are identical to the no-pop run.
- Back-to-back pops: `pop` high for 10 consecutive cycles with the queue full.
  - Each edge, slot i takes the old slot i+1.
  - `queue_ready` never drops.
- Seed handling:
  - `seed_load` with `seed`=0 gives the same subsequent sequence as reset seed 0xACE1.
  - `seed`=0x1234 loaded at the same point in two runs yields identical sequences.
- Reset mid-stream: assert `rst` one cycle while full and popping. Next cycle the queue is all BLANK and `queue_ready`=0, then the reset-fill sequence repeats exactly.
